// File: rtl/four_bank_mem_ctl.sv
// Word-interleaved four-bank main memory behind the cache: one request per cycle,
// per-bank busy counters, combinational stall/err, and a fixed-latency read pipeline.
module four_bank_mem_ctl #(
  parameter int BUSY_CYCLES = 4,
  parameter int READ_LAT    = 2,
  parameter int BANK_AW     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int CW = 4;
  // Address bits above the row field must be zero; the mask is empty when the row reaches bit 15.
  localparam logic [31:0] HI_MASK_W = 32'hFFFF_FFFF << (BANK_AW + 3);
  localparam logic [15:0] HI_MASK   = HI_MASK_W[15:0];

  logic [CW-1:0]      cnt [4];
  logic [15:0]        mem [4][2**BANK_AW];
  logic [READ_LAT-1:0] pipe_v;
  logic [15:0]        pipe_d [READ_LAT];

  logic [1:0]         bank;
  logic [BANK_AW-1:0] row;
  logic               req;
  logic               illegal;
  logic               accept;

  assign bank    = addr[2:1];
  assign row     = addr[BANK_AW+2:3];
  assign req     = rd | wr;
  assign illegal = (rd & wr) | addr[0] | (|(addr & HI_MASK));
  assign err     = req & illegal;
  assign stall   = req & ~illegal & busy[bank];
  assign accept  = ~rst & req & ~illegal & ~busy[bank];

  always_comb begin
    busy = '0;
    for (int b = 0; b < 4; b++) busy[b] = (cnt[b] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && bank == 2'(b)) cnt[b] <= CW'(BUSY_CYCLES);
        else if (cnt[b] != '0)       cnt[b] <= cnt[b] - 1'b1;
      end
    end
  end

  // Array contents are never reset; only accepted writes change them.
  always_ff @(posedge clk) begin
    if (accept && wr) mem[bank][row] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept & rd;
      for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Data slots need no reset: an invalid slot is masked to zero at the output.
  always_ff @(posedge clk) begin
    pipe_d[0] <= mem[bank][row];
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign data_out = pipe_v[READ_LAT-1] ? pipe_d[READ_LAT-1] : 16'h0000;

endmodule

// File: tb/tb_four_bank_mem_ctl.sv
// Bench for four_bank_mem_ctl: directed scenarios plus random traffic against a
// cycle-indexed reference model; read data checked by a separate monitor.
module tb_four_bank_mem_ctl;

  localparam int BUSY_CYCLES = 4;
  localparam int READ_LAT    = 2;
  localparam int BANK_AW     = 13;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic [3:0]  busy;
  logic        stall, err;

  four_bank_mem_ctl #(
    .BUSY_CYCLES(BUSY_CYCLES), .READ_LAT(READ_LAT), .BANK_AW(BANK_AW)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .busy(busy), .stall(stall), .err(err)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // reference model: bank b is busy in cycle c while c < free_at[b]
  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] model_mem [4][2**BANK_AW];
  bit          written   [4][2**BANK_AW];
  int          free_at   [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // drive one cycle, check combinational/busy outputs, then advance the model
  task automatic step(input bit r, input bit rdi, input bit wri,
                      input logic [15:0] a, input logic [15:0] d, output bit accepted);
    bit req, illegal, exp_stall, exp_err;
    int b, row;
    logic [3:0] exp_busy;
    rst = r; rd = rdi; wr = wri; addr = a; data_in = d;
    b = int'(a[2:1]);
    row = int'(a[15:3]);
    req = rdi | wri;
    illegal = (rdi & wri) | a[0];
    for (int k = 0; k < 4; k++) exp_busy[k] = (cyc < free_at[k]);
    exp_err = req & illegal;
    exp_stall = req & !illegal & exp_busy[b];
    @(negedge clk);
    check("err", {15'b0, err}, {15'b0, exp_err});
    check("stall", {15'b0, stall}, {15'b0, exp_stall});
    check("busy", {12'b0, busy}, {12'b0, exp_busy});
    accepted = !r && req && !illegal && !exp_busy[b];
    if (r) begin
      for (int k = 0; k < 4; k++) free_at[k] = 0;
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].due > cyc) exp_q.delete(i);
    end else if (accepted) begin
      free_at[b] = cyc + BUSY_CYCLES + 1;
      if (wri) begin
        model_mem[b][row] = d;
        written[b][row] = 1'b1;
      end else begin
        exp_q.push_back('{cyc + READ_LAT, model_mem[b][row]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0000, 16'h0000, acc);
  endtask

  // requester holds the request until the bank accepts it (bounded)
  task automatic req_hold(input bit rdi, input bit wri, input logic [15:0] a, input logic [15:0] d);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      step(0, rdi, wri, a, d, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL hold_timeout cycle %0d: got not_accepted expected accepted", cyc);
    end
  endtask

  // monitor: every cycle data_out is either the due read or zero
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("read_data", data_out, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check("idle_data_out", data_out, 16'h0000);
      end
    end
  end

  initial begin
    bit acc;
    logic [15:0] a;
    int op, b, row;
    for (int k = 0; k < 4; k++) free_at[k] = 0;
    rst = 1; rd = 0; wr = 0; addr = 0; data_in = 0;
    repeat (2) @(posedge clk);
    #1;
    started = 1;
    idle(2);

    // 1: write then read one word in bank 0
    step(0, 0, 1, 16'h0010, 16'hBEEF, acc);
    idle(4);
    req_hold(1, 0, 16'h0010, 16'h0000);
    idle(3);

    // 2: fill all four banks, then stream them back
    step(0, 0, 1, 16'h0100, 16'h1111, acc);
    step(0, 0, 1, 16'h0102, 16'h2222, acc);
    step(0, 0, 1, 16'h0104, 16'h3333, acc);
    step(0, 0, 1, 16'h0106, 16'h4444, acc);
    req_hold(1, 0, 16'h0100, 16'h0);
    req_hold(1, 0, 16'h0102, 16'h0);
    req_hold(1, 0, 16'h0104, 16'h0);
    req_hold(1, 0, 16'h0106, 16'h0);
    idle(5);

    // 3: same-bank conflict, held and retried
    step(0, 0, 1, 16'h0020, 16'hA020, acc);
    step(0, 0, 1, 16'h0028, 16'hA028, acc);
    idle(5);
    step(0, 1, 0, 16'h0020, 16'h0, acc);
    req_hold(1, 0, 16'h0028, 16'h0);
    idle(4);

    // 4: illegal requests
    step(0, 1, 1, 16'h0040, 16'h1234, acc);
    step(0, 1, 0, 16'h0041, 16'h0, acc);
    idle(3);

    // 5: reset discards an in-flight read
    step(0, 0, 1, 16'h0002, 16'hC0DE, acc);
    idle(5);
    step(0, 1, 0, 16'h0002, 16'h0, acc);
    step(1, 0, 0, 16'h0000, 16'h0, acc);
    step(0, 1, 0, 16'h0002, 16'h0, acc);
    idle(4);

    // 6: write during reset is ignored
    step(1, 0, 1, 16'h0030, 16'h5A5A, acc);
    step(0, 0, 1, 16'h0030, 16'h0001, acc);
    idle(4);
    req_hold(1, 0, 16'h0030, 16'h0);
    idle(4);

    // random traffic over a small address pool
    for (int i = 0; i < 600; i++) begin
      b = $urandom_range(0, 3);
      row = ($urandom_range(0, 9) == 0) ? (2**BANK_AW - 1) : $urandom_range(0, 7);
      a = {row[12:0], b[1:0], 1'b0};
      op = $urandom_range(0, 99);
      if (op < 2) begin
        step(1, $urandom_range(0, 1), $urandom_range(0, 1), a, 16'($urandom), acc);
      end else if (op < 6) begin
        step(0, 1, 1, a, 16'($urandom), acc);
      end else if (op < 10) begin
        step(0, $urandom_range(0, 1), 1'b1, a | 16'h0001, 16'($urandom), acc);
      end else if (op < 20) begin
        idle(1);
      end else if (op < 55 || !written[b][row]) begin
        step(0, 0, 1, a, 16'($urandom), acc);
      end else begin
        step(0, 1, 0, a, 16'h0, acc);
      end
    end
    idle(BUSY_CYCLES + READ_LAT + 2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain cycle %0d: got %0d pending reads expected 0", cyc, exp_q.size());
    end
    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
